// File: rtl/ssd_decoder.sv
// ============================================================================
// Module   : ssd_decoder
// Purpose  : Receive-side decoder for a multiplexed, active-low seven-segment
//            bus. Waits for each anode dwell to settle, decodes the segment
//            pattern back to a hex nibble per digit, reassembles the displayed
//            value, flags illegal patterns and pulses once per full frame.
// Options  : SSD_DECODER_BLANK_EN - when defined, an all-segments-off pattern
//            is tolerated as a blanked digit instead of an error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd_decoder #(
  parameter int DIGITS = 8,
  parameter int SETTLE = 4
) (
  input  logic                ssd_decoder_port_clk,
  input  logic                ssd_decoder_port_rst,
  input  logic [6:0]          ssd_decoder_port_ssd,
  input  logic                ssd_decoder_port_idp,
  input  logic [DIGITS-1:0]   ssd_decoder_port_an,
  output logic [4*DIGITS-1:0] ssd_decoder_port_value,
  output logic [DIGITS-1:0]   ssd_decoder_port_dp,
  output logic [DIGITS-1:0]   ssd_decoder_port_vld,
  output logic                ssd_decoder_port_frame,
  output logic                ssd_decoder_port_err
);

  localparam int                KW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] C_ONE    = DIGITS'(1);
  localparam logic [8:0]        C_SETTLE = 9'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  // Input stage (s1) and its one-cycle-older copy (s2)
  logic [6:0]          r_s1_ssd, r_s2_ssd;
  logic                r_s1_idp, r_s2_idp;
  logic [DIGITS-1:0]   r_s1_an,  r_s2_an;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_cnt, w_cnt_nxt;
  logic [8:0]          w_cnt_inc;
  logic                w_capture;

  logic [DIGITS-1:0]   w_an_act;
  logic                w_onehot;
  logic                w_changed;
  logic [KW-1:0]       w_idx;
  logic [4:0]          w_dec;
  logic                w_hit;
  logic                w_blank;

  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_vld;
  logic [DIGITS-1:0]   r_mask;
  logic                r_frame;
  logic                r_err;

  // Returns {hit, nibble} for an active-low gfedcba pattern
  function automatic logic [4:0] f_decode(input logic [6:0] pat);
    case (pat)
      7'b1000000: f_decode = 5'h10;
      7'b1111001: f_decode = 5'h11;
      7'b0100100: f_decode = 5'h12;
      7'b0110000: f_decode = 5'h13;
      7'b0011001: f_decode = 5'h14;
      7'b0010010: f_decode = 5'h15;
      7'b0000010: f_decode = 5'h16;
      7'b1111000: f_decode = 5'h17;
      7'b0000000: f_decode = 5'h18;
      7'b0010000: f_decode = 5'h19;
      7'b0001000: f_decode = 5'h1A;
      7'b0000011: f_decode = 5'h1B;
      7'b1000110: f_decode = 5'h1C;
      7'b0100001: f_decode = 5'h1D;
      7'b0000110: f_decode = 5'h1E;
      7'b0001110: f_decode = 5'h1F;
      default:    f_decode = 5'h00;
    endcase
  endfunction

  // Anode one-hot test on the newest sample; change test across all lines
  assign w_an_act  = ~r_s1_an;
  assign w_onehot  = (w_an_act != '0) && ((w_an_act & (w_an_act - C_ONE)) == '0);
  assign w_changed = (r_s1_ssd != r_s2_ssd) || (r_s1_idp != r_s2_idp) ||
                     (r_s1_an != r_s2_an);
  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

  // Capture always uses s2: it is the copy that was just proven stable
  assign w_dec   = f_decode(r_s2_ssd);
  assign w_hit   = w_dec[4];
  assign w_blank = (r_s2_ssd == 7'h7F);

  // Digit index = position of the low anode bit in the stable copy
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!r_s2_an[i]) w_idx = KW'(i);
    end
  end

  // Register the bus once and keep the previous sample for change detection
  always_ff @(posedge ssd_decoder_port_clk or negedge ssd_decoder_port_rst) begin
    if (!ssd_decoder_port_rst) begin
      r_s1_ssd <= 7'h7F;
      r_s2_ssd <= 7'h7F;
      r_s1_idp <= 1'b1;
      r_s2_idp <= 1'b1;
      r_s1_an  <= '1;
      r_s2_an  <= '1;
    end else begin
      r_s1_ssd <= ssd_decoder_port_ssd;
      r_s2_ssd <= r_s1_ssd;
      r_s1_idp <= ssd_decoder_port_idp;
      r_s2_idp <= r_s1_idp;
      r_s1_an  <= ssd_decoder_port_an;
      r_s2_an  <= r_s1_an;
    end
  end

  // FSM state and settle counter
  always_ff @(posedge ssd_decoder_port_clk or negedge ssd_decoder_port_rst) begin
    if (!ssd_decoder_port_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: settle, capture once, then hold until the dwell ends
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_onehot) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (w_changed) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_onehot ? ST_SETTLE : ST_IDLE;
        end else if (w_cnt_inc == C_SETTLE) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_cnt_nxt = w_cnt_inc[7:0];
        end
      end
      ST_CAPTURE: begin
        // A dwell ending right at capture must not be missed by HOLD
        w_capture = 1'b1;
        w_cnt_nxt = '0;
        if (w_changed) w_state_nxt = w_onehot ? ST_SETTLE : ST_IDLE;
        else           w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_changed) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_onehot ? ST_SETTLE : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Per-digit capture, sticky error and frame completion tracking
  always_ff @(posedge ssd_decoder_port_clk or negedge ssd_decoder_port_rst) begin
    if (!ssd_decoder_port_rst) begin
      r_value <= '0;
      r_dp    <= '0;
      r_vld   <= '0;
      r_mask  <= '0;
      r_frame <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      if (&r_mask) begin
        r_frame <= 1'b1;
        r_mask  <= '0;
      end
      if (w_capture) begin
        r_mask[w_idx] <= 1'b1;
        r_dp[w_idx]   <= ~r_s2_idp;
        if (w_hit) begin
          r_value[w_idx*4 +: 4] <= w_dec[3:0];
          r_vld[w_idx]          <= 1'b1;
        end else begin
          r_vld[w_idx] <= 1'b0;
`ifdef SSD_DECODER_BLANK_EN
          if (w_blank) r_value[w_idx*4 +: 4] <= 4'h0;
          else         r_err <= 1'b1;
`else
          r_err <= 1'b1;
`endif
        end
      end
    end
  end

`ifndef SSD_DECODER_BLANK_EN
  // Blank detection only matters when blanking is tolerated
  logic w_unused;
  assign w_unused = w_blank;
`endif

  assign ssd_decoder_port_value = r_value;
  assign ssd_decoder_port_dp    = r_dp;
  assign ssd_decoder_port_vld   = r_vld;
  assign ssd_decoder_port_frame = r_frame;
  assign ssd_decoder_port_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ssd_decoder.sv
// ============================================================================
// Module   : tb_ssd_decoder
// Purpose  : Directed self-checking bench for ssd_decoder (DIGITS=8, SETTLE=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ssd_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  ssd;
  logic        idp;
  logic [7:0]  an;
  logic [31:0] value;
  logic [7:0]  dp;
  logic [7:0]  vld;
  logic        frame;
  logic        err;

  int total  = 0;
  int bad    = 0;
  int fcount = 0;

  logic [6:0]  seg [16];
  logic [31:0] ev;
  logic        eerr;

  ssd_decoder #(.DIGITS(8), .SETTLE(4)) dut (
    .ssd_decoder_port_clk   (clk),
    .ssd_decoder_port_rst   (rst_n),
    .ssd_decoder_port_ssd   (ssd),
    .ssd_decoder_port_idp   (idp),
    .ssd_decoder_port_an    (an),
    .ssd_decoder_port_value (value),
    .ssd_decoder_port_dp    (dp),
    .ssd_decoder_port_vld   (vld),
    .ssd_decoder_port_frame (frame),
    .ssd_decoder_port_err   (err)
  );

  always #5 clk = ~clk;

  // Count frame pulses seen on rising edges
  always @(posedge clk) if (frame === 1'b1) fcount++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one dwell for 'cyc' rising edges; starts and ends 1ns after an edge
  task automatic dwell(input int idx, input logic [6:0] pat, input logic dpv, input int cyc);
    an  = ~(8'd1 << idx);
    ssd = pat;
    idp = ~dpv;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  initial begin
    seg[0]  = 7'b1000000; seg[1]  = 7'b1111001; seg[2]  = 7'b0100100; seg[3]  = 7'b0110000;
    seg[4]  = 7'b0011001; seg[5]  = 7'b0010010; seg[6]  = 7'b0000010; seg[7]  = 7'b1111000;
    seg[8]  = 7'b0000000; seg[9]  = 7'b0010000; seg[10] = 7'b0001000; seg[11] = 7'b0000011;
    seg[12] = 7'b1000110; seg[13] = 7'b0100001; seg[14] = 7'b0000110; seg[15] = 7'b0001110;

    rst_n = 1'b0;
    an    = 8'hFF;
    ssd   = 7'h7F;
    idp   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", value, 32'h0);
    check("rst_vld",   {24'h0, vld}, 32'h0);
    check("rst_dp",    {24'h0, dp},  32'h0);
    check("rst_frame", {31'h0, frame}, 32'h0);
    check("rst_err",   {31'h0, err},   32'h0);
    rst_n = 1'b1;

    // Single digit: capture lands exactly 6 edges after the first sampling edge
    an = 8'hFE; ssd = seg[1]; idp = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("lat_before", value, 32'h0);
    @(posedge clk); #1;
    check("lat_value", value, 32'h1);
    check("lat_vld",   {24'h0, vld}, 32'h1);
    check("lat_err",   {31'h0, err}, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    // Full scan 0..7 with dp on digit 3; frame one cycle after digit 7 capture
    for (int d = 0; d < 7; d++) dwell(d, seg[d], (d == 3), 8);
    an = 8'h7F; ssd = seg[7]; idp = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("scan_value", value, 32'h76543210);
    check("scan_frame_lo", {31'h0, frame}, 32'h0);
    @(posedge clk); #1;
    check("scan_frame_hi", {31'h0, frame}, 32'h1);
    @(posedge clk); #1;
    check("scan_frame_end", {31'h0, frame}, 32'h0);
    check("scan_vld", {24'h0, vld}, 32'hFF);
    check("scan_dp",  {24'h0, dp},  32'h08);
    check("scan_fcount", fcount, 1);

    // Scan with digit 2 dwell too short: digit 2 kept, no frame
    dwell(0, seg[8], 1'b0, 8);
    dwell(1, seg[9], 1'b0, 8);
    dwell(2, seg[10], 1'b0, 4);
    for (int d = 3; d < 8; d++) dwell(d, seg[8 + d], 1'b0, 8);
    dwell(7, seg[15], 1'b0, 8);
    check("short_value", value, 32'hFEDCB298);
    check("short_vld", {24'h0, vld}, 32'hFF);
    check("short_fcount", fcount, 1);

    // Two anodes low for 20 cycles: nothing captured
    dwell(0, seg[5], 1'b0, 1);
    an = 8'hFC; ssd = seg[5]; idp = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("dual_value", value, 32'hFEDCB298);
    check("dual_fcount", fcount, 1);

    // Reset in the middle of a SETTLE after 7 digits captured
    an = 8'hFB; ssd = seg[4]; idp = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_value", value, 32'h0);
    check("mid_rst_vld", {24'h0, vld}, 32'h0);
    check("mid_rst_err", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_value", value, 32'h00000400);
    check("post_rst_vld", {24'h0, vld}, 32'h04);
    check("post_rst_fcount", fcount, 1);

    // Fresh full scan needed for the next frame
    dwell(0, seg[3], 1'b0, 8);
    dwell(1, seg[1], 1'b0, 8);
    dwell(2, seg[4], 1'b0, 8);
    dwell(3, seg[1], 1'b0, 8);
    dwell(4, seg[5], 1'b0, 8);
    dwell(5, seg[9], 1'b0, 8);
    dwell(6, seg[2], 1'b0, 8);
    check("rescan_fcount_pre", fcount, 1);
    dwell(7, seg[6], 1'b0, 8);
    check("rescan_value", value, 32'h62951413);

    // All segments off on digit 0
    dwell(0, 7'h7F, 1'b0, 8);
    check("rescan_fcount", fcount, 2);
`ifdef SSD_DECODER_BLANK_EN
    ev = 32'h62951410; eerr = 1'b0;
`else
    ev = 32'h62951413; eerr = 1'b1;
`endif
    check("blank_value", value, ev);
    check("blank_vld", {24'h0, vld}, 32'hFE);
    check("blank_err", {31'h0, err}, {31'h0, eerr});

    // Illegal pattern on digit 5
    an = 8'hFC; ssd = seg[0]; idp = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("dual2_value", value, ev);
    dwell(5, 7'b0101010, 1'b0, 8);
    check("illegal_err", {31'h0, err}, 32'h1);
    check("illegal_vld", {24'h0, vld}, 32'hDE);
    check("illegal_value", value, ev);
    check("final_fcount", fcount, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ssd_decoder.md
# ssd_decoder

Receive-side decoder for the multiplexed seven-segment bus produced by the counter/display top: samples the active-low segment, decimal-point and anode lines, waits for each anode dwell to settle, and converts the segment pattern back to a hex nibble per digit. It reassembles the full displayed value, flags illegal patterns, and pulses once per completed scan frame. It lets benches and on-board self-test check what the display actually shows, not the counter's internal state.

## Interface
- DIGITS, 8: number of anodes/digits decoded (1..8).
- SETTLE, 4: consecutive identical samples required before a dwell is captured (1..255).
- ssd_decoder_port_clk  input  1  system clock; all state on rising edge.
- ssd_decoder_port_rst  input  1  reset, asynchronous, active-low.
- ssd_decoder_port_ssd  input  7  segments, active-low, bit0=a … bit6=g.
- ssd_decoder_port_idp  input  1  decimal point, active-low.
- ssd_decoder_port_an  input  DIGITS  anodes, active-low, one-hot when driving.
- ssd_decoder_port_value  output  4*DIGITS  decoded nibbles; digit i at [4i+3:4i].
- ssd_decoder_port_dp  output  DIGITS  captured decimal point per digit, active-high.
- ssd_decoder_port_vld  output  DIGITS  digit i holds a legally decoded pattern.
- ssd_decoder_port_frame  output  1  one-cycle pulse per completed frame.
- ssd_decoder_port_err  output  1  sticky illegal-pattern flag.

## Operation
- Reset: value=0, dp=0, vld=0, frame=0, err=0, capture mask=0, settle counter=0, FSM=IDLE.
- Input stage: ssd/idp/an registered once (s1); all decisions use s1 and its previous copy s2.
- FSM IDLE: an not exactly one-hot (none or several low) -> stay; counter=0. One-hot -> SETTLE.
- FSM SETTLE: s1==s2 on all lines -> counter+1; any change -> counter=0, re-evaluate one-hot (back to IDLE if not). Counter reaches SETTLE -> CAPTURE.
- FSM CAPTURE (one cycle): digit index k = position of low anode bit. Decode pattern (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Match: value[k]=nibble, vld[k]=1. No match: value[k] unchanged, vld[k]=0, err=1. dp[k]=~idp. mask[k]=1. -> HOLD.
- FSM HOLD: no further capture until s1 differs from s2 (new dwell) -> counter=0, IDLE/SETTLE per one-hot test. Guarantees exactly one capture per dwell.
- Frame: when mask[DIGITS-1:0] becomes all ones, frame pulses the next cycle and mask clears same edge. Recapture of an already-masked digit overwrites value, no frame.
- Reset mid-operation: all state to reset values immediately; partial frame discarded.
- err clears only on reset.

## Timing
- Capture latency: value/vld/dp update on the edge SETTLE+2 cycles after the first edge sampling the new stable pattern (1 input register + SETTLE stable compares + CAPTURE).
- Dwell shorter than SETTLE+1 cycles is never captured.
- frame: high exactly one cycle, one cycle after the final digit's capture edge.
- Anode change and segment change on the same cycle: treated as one change; counter restarts.

## Configuration
- SSD_DECODER_BLANK_EN defined: all-segments-off (1111111) is legal: value[k]=0, vld[k]=0, err unchanged, mask[k]=1 (leading-zero blanking tolerated).
- Not defined: 1111111 is illegal: vld[k]=0, err=1, mask[k]=1.

## Test plan
- Reset 3 cycles, then an=11111110, ssd=1111001 held 10 cycles (SETTLE=4) -> value[3:0]=1, vld[0]=1, err=0; update exactly 6 edges after first sampling edge.
- Scan digits 0..7 showing 0,1,…,7, dwell 8 cycles each -> value=32'h76543210, vld=8'hFF, frame single pulse after digit 7; no second pulse until another full scan.
- Digit 2 dwell only 4 cycles (SETTLE=4) -> digit 2 not captured, mask incomplete, no frame.
- an=11111100 (two low) for 20 cycles -> no capture, all outputs unchanged; ssd=0101010 on digit 5 -> err=1, vld[5]=0, value[23:20] unchanged.
- ssd=1111111 on digit 0: with SSD_DECODER_BLANK_EN -> err=0, vld[0]=0; without -> err=1.
- Assert reset mid-SETTLE after 7 digits captured -> all outputs 0 immediately; next full scan required for frame.
